// File: rtl/cpu.sv
// SRAM programmer bus master: writes a pattern to DEPTH words over a multiplexed
// 20-bit address / 16-bit data bus, reads every word back and reports done/err.
module cpu #(
  parameter int          DEPTH = 256,
  parameter logic [19:0] BASE  = 20'h0,
  parameter logic [15:0] SEED  = 16'h0
) (
  input  logic clk,
  input  logic rst_n,
  inout  wire  io1,
  inout  wire  io2,
  inout  wire  io3,
  inout  wire  io4,
  inout  wire  io5,
  inout  wire  io6,
  inout  wire  io7,
  inout  wire  io8,
  inout  wire  io9,
  inout  wire  io10,
  inout  wire  io11,
  inout  wire  io12,
  inout  wire  io13,
  inout  wire  io14,
  inout  wire  io15,
  inout  wire  io16,
  output logic io17,
  output logic io18,
  output logic io19,
  output logic io20,
  output logic pio,
  output logic oe,
  output logic ale,
  output logic we,
  output logic done,
  output logic err
);

  typedef enum logic [1:0] {S_WRITE, S_VERIFY, S_DONE} state_e;
  typedef enum logic [1:0] {T1, T2, T3, T4} phase_e;

  state_e     state_q, state_d;
  phase_e     phase_q, phase_d;
  logic       run_q, run_d;
  logic [8:0] n_q, n_d;
  logic       err_q, err_d;

  logic        active, strobe, ad_en;
  logic [19:0] addr;
  logic [15:0] pat, ad_out, ad_in;

  assign io1  = ad_en ? ad_out[15] : 1'bz;
  assign io2  = ad_en ? ad_out[14] : 1'bz;
  assign io3  = ad_en ? ad_out[13] : 1'bz;
  assign io4  = ad_en ? ad_out[12] : 1'bz;
  assign io5  = ad_en ? ad_out[11] : 1'bz;
  assign io6  = ad_en ? ad_out[10] : 1'bz;
  assign io7  = ad_en ? ad_out[9]  : 1'bz;
  assign io8  = ad_en ? ad_out[8]  : 1'bz;
  assign io9  = ad_en ? ad_out[7]  : 1'bz;
  assign io10 = ad_en ? ad_out[6]  : 1'bz;
  assign io11 = ad_en ? ad_out[5]  : 1'bz;
  assign io12 = ad_en ? ad_out[4]  : 1'bz;
  assign io13 = ad_en ? ad_out[3]  : 1'bz;
  assign io14 = ad_en ? ad_out[2]  : 1'bz;
  assign io15 = ad_en ? ad_out[1]  : 1'bz;
  assign io16 = ad_en ? ad_out[0]  : 1'bz;
  assign ad_in = {io1, io2, io3, io4, io5, io6, io7, io8,
                  io9, io10, io11, io12, io13, io14, io15, io16};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WRITE;
      phase_q <= T1;
      run_q   <= 1'b0;
      n_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      run_q   <= run_d;
      n_q     <= n_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    run_d   = 1'b1;
    n_d     = n_q;
    err_d   = err_q;

    // run_q holds off the first bus cycle for one clock after reset release
    active = run_q && (state_q != S_DONE);
    strobe = active && (phase_q == T2 || phase_q == T3);
    addr   = BASE + 20'(n_q);
    pat    = {~n_q[7:0], n_q[7:0]} ^ SEED;

    ale    = active && (phase_q == T1);
    pio    = !strobe;
    oe     = !strobe;
    we     = !(strobe && state_q == S_WRITE);
    ad_en  = ale || (strobe && state_q == S_WRITE);
    ad_out = (phase_q == T1) ? addr[15:0] : pat;
    {io17, io18, io19, io20} = active ? addr[19:16] : 4'h0;
    done   = (state_q == S_DONE);
    err    = err_q;

    if (active) begin
      phase_d = phase_e'(phase_q + 2'd1);
      if (phase_q == T3 && state_q == S_VERIFY && ad_in != pat)
        err_d = 1'b1;
      if (phase_q == T4) begin
        if (n_q == 9'(DEPTH - 1)) begin
          n_d     = '0;
          state_d = (state_q == S_WRITE) ? S_VERIFY : S_DONE;
        end else begin
          n_d = n_q + 9'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: board model ('573 latch, '138 select, '245, SRAM) around two
// instances (DEPTH=4 plain, DEPTH=2 with SEED), table vectors plus directed sequences.
module tb_cpu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic fault = 1'b0;

  // instance A: DEPTH=4, SEED=0
  wire  [15:0] ad_a;
  logic [3:0]  hi_a;
  logic        pio_a, oe_a, ale_a, we_a, done_a, err_a;
  logic [19:0] lat_a = '0;
  logic [15:0] mem_a [0:255];
  logic [15:0] rd_a;

  // instance B: DEPTH=2, SEED=A5A5
  wire  [15:0] ad_b;
  logic [3:0]  hi_b;
  logic        pio_b, oe_b, ale_b, we_b, done_b, err_b;
  logic [19:0] lat_b = '0;
  logic [15:0] mem_b [0:255];

  // released bus lines read back as all ones
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (ad_a[i]);
    pullup (ad_b[i]);
  end

  cpu #(.DEPTH(4), .BASE(20'h0), .SEED(16'h0)) u_a (
    .clk(clk), .rst_n(rst_n),
    .io1(ad_a[15]), .io2(ad_a[14]), .io3(ad_a[13]), .io4(ad_a[12]),
    .io5(ad_a[11]), .io6(ad_a[10]), .io7(ad_a[9]),  .io8(ad_a[8]),
    .io9(ad_a[7]),  .io10(ad_a[6]), .io11(ad_a[5]), .io12(ad_a[4]),
    .io13(ad_a[3]), .io14(ad_a[2]), .io15(ad_a[1]), .io16(ad_a[0]),
    .io17(hi_a[3]), .io18(hi_a[2]), .io19(hi_a[1]), .io20(hi_a[0]),
    .pio(pio_a), .oe(oe_a), .ale(ale_a), .we(we_a), .done(done_a), .err(err_a));

  cpu #(.DEPTH(2), .BASE(20'h0), .SEED(16'hA5A5)) u_b (
    .clk(clk), .rst_n(rst_n),
    .io1(ad_b[15]), .io2(ad_b[14]), .io3(ad_b[13]), .io4(ad_b[12]),
    .io5(ad_b[11]), .io6(ad_b[10]), .io7(ad_b[9]),  .io8(ad_b[8]),
    .io9(ad_b[7]),  .io10(ad_b[6]), .io11(ad_b[5]), .io12(ad_b[4]),
    .io13(ad_b[3]), .io14(ad_b[2]), .io15(ad_b[1]), .io16(ad_b[0]),
    .io17(hi_b[3]), .io18(hi_b[2]), .io19(hi_b[1]), .io20(hi_b[0]),
    .pio(pio_b), .oe(oe_b), .ale(ale_b), .we(we_b), .done(done_b), .err(err_b));

  // board A: latch on ale, SRAM selected when pio low and A[18:16]==0
  always @(posedge clk) begin
    if (ale_a) lat_a <= {hi_a, ad_a};
    if (!pio_a && !oe_a && !we_a && lat_a[18:16] == 3'd0) mem_a[lat_a[7:0]] <= ad_a;
  end
  assign rd_a = (fault && lat_a[7:0] == 8'd2) ? 16'h0000 : mem_a[lat_a[7:0]];
  assign ad_a = (!pio_a && !oe_a && we_a && lat_a[18:16] == 3'd0) ? rd_a : 16'hzzzz;

  always @(posedge clk) begin
    if (ale_b) lat_b <= {hi_b, ad_b};
    if (!pio_b && !oe_b && !we_b && lat_b[18:16] == 3'd0) mem_b[lat_b[7:0]] <= ad_b;
  end
  assign ad_b = (!pio_b && !oe_b && we_b && lat_b[18:16] == 3'd0) ? mem_b[lat_b[7:0]] : 16'hzzzz;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic to_cyc(input int t);
    int k = 0;
    while (cyc != t && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("cycle_reached", 32'(cyc), 32'(t));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ctl", {26'd0, ale_a, pio_a, oe_a, we_a, done_a, err_a}, 32'b011100);
    chk("rst_bus", {12'd0, hi_a, ad_a}, 32'h0000FFFF);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // bus protocol monitor on instance A
  always @(negedge clk) begin
    n_chk += 3;
    if (!we_a && (pio_a || oe_a)) begin
      n_fail++; $display("FAIL we_gate: we low while pio=%b oe=%b", pio_a, oe_a);
    end
    if (ale_a && !pio_a) begin
      n_fail++; $display("FAIL ale_pio: ale high while pio low");
    end
    if (pio_a && !ale_a && ad_a !== 16'hFFFF) begin
      n_fail++; $display("FAIL turnaround: bus %h expected released", ad_a);
    end
  end

  typedef struct {
    int          cyc;
    logic [5:0]  ctl;  // {ale, pio, oe, we, done, err}
    logic [15:0] ad;
  } vec_t;

  vec_t vt [13];

  initial begin
    vt[0]  = '{1,  6'b111100, 16'h0000};
    vt[1]  = '{2,  6'b000000, 16'hFF00};
    vt[2]  = '{3,  6'b000000, 16'hFF00};
    vt[3]  = '{4,  6'b011100, 16'hFFFF};
    vt[4]  = '{5,  6'b111100, 16'h0001};
    vt[5]  = '{6,  6'b000000, 16'hFE01};
    vt[6]  = '{14, 6'b000000, 16'hFC03};
    vt[7]  = '{16, 6'b011100, 16'hFFFF};
    vt[8]  = '{17, 6'b111100, 16'h0000};
    vt[9]  = '{18, 6'b000100, 16'hFF00};
    vt[10] = '{30, 6'b000100, 16'hFC03};
    vt[11] = '{32, 6'b011100, 16'hFFFF};
    vt[12] = '{33, 6'b011110, 16'hFFFF};

    // plain write/verify run
    do_reset();
    for (int i = 0; i < 13; i++) begin
      to_cyc(vt[i].cyc);
      chk($sformatf("vec%0d_ctl", i), {26'd0, ale_a, pio_a, oe_a, we_a, done_a, err_a},
          {26'd0, vt[i].ctl});
      chk($sformatf("vec%0d_ad", i), {16'd0, ad_a}, {16'd0, vt[i].ad});
    end
    chk("sram0", {16'd0, mem_a[0]}, 32'hFF00);
    chk("sram1", {16'd0, mem_a[1]}, 32'hFE01);
    chk("sram2", {16'd0, mem_a[2]}, 32'hFD02);
    chk("sram3", {16'd0, mem_a[3]}, 32'hFC03);

    // read-back fault on word 2
    fault = 1'b1;
    do_reset();
    to_cyc(27); chk("fault_err_before", {31'd0, err_a}, 32'd0);
    to_cyc(28); chk("fault_err_set", {31'd0, err_a}, 32'd1);
    to_cyc(32); chk("fault_done_before", {31'd0, done_a}, 32'd0);
    to_cyc(33); chk("fault_done", {30'd0, done_a, err_a}, 32'b11);
    fault = 1'b0;

    // reset pulsed during write word 1, T3
    do_reset();
    to_cyc(7);
    chk("w1_t3_addr", {12'd0, lat_a}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ctl", {26'd0, ale_a, pio_a, oe_a, we_a, done_a, err_a}, 32'b011100);
    chk("async_bus", {12'd0, hi_a, ad_a}, 32'h0000FFFF);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    to_cyc(1);
    chk("restart_ale", {31'd0, ale_a}, 32'd1);
    chk("restart_addr", {16'd0, ad_a}, 32'h0000);
    to_cyc(2);
    chk("restart_lat", {12'd0, lat_a}, 32'h0);
    chk("restart_data", {16'd0, ad_a}, 32'hFF00);

    // seeded instance
    to_cyc(16); chk("seed_done_before", {31'd0, done_b}, 32'd0);
    to_cyc(17); chk("seed_done", {30'd0, done_b, err_b}, 32'b10);
    chk("seed_w0", {16'd0, mem_b[0]}, 32'h5AA5);
    chk("seed_w1", {16'd0, mem_b[1]}, 32'h5BA4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
